cntr_bs_buf: RTL and testbench



---
 rtl/cntr_pkg.sv | 42 ++++
 rtl/cntr_bs_buf_if.sv | 37 +++
 rtl/cntr_bs_fifo.sv | 73 +++++++
 rtl/cntr_bs_buf.sv | 150 +++++++++++++++
 tb/tb_cntr_bs_buf.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cntr_pkg.sv
// Shared constants, mode encoding and sizing helpers for the bank-scheduler
// request buffer.
package cntr_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic {
    MODE_WR = 1'b0,
    MODE_RD = 1'b1
  } mode_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int fifo_num(input int rd_num, input int wr_num);
    return rd_num + wr_num;
  endfunction

  // Thread index must address the larger of the two FIFO groups.
  function automatic int thr_w(input int rd_num, input int wr_num);
    int m;
    m = max2(rd_num, wr_num);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Write FIFOs sit above the read FIFOs in the flat index space.
  function automatic int fifo_idx(input logic is_rd, input int thread, input int rd_num);
    return is_rd ? thread : (rd_num + thread);
  endfunction

  function automatic int popcnt(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cntr_bs_buf_if.sv
// Request/scheduler bundle of the bank request buffer; master drives requests
// and pops, slave is the buffer itself.
interface cntr_bs_buf_if #(
  parameter int RD_FIFO_NUM = 4,
  parameter int WR_FIFO_NUM = 3,
  parameter int BURST       = 16,
  parameter int REQ_W       = 32
);
  import cntr_pkg::*;

  localparam int FIFO_NUM = fifo_num(RD_FIFO_NUM, WR_FIFO_NUM);
  localparam int THR_W    = thr_w(RD_FIFO_NUM, WR_FIFO_NUM);

  logic                              valid_i;
  logic                              ready_o;
  logic                              type_i;
  logic [THR_W-1:0]                  thread_i;
  logic [BURST-1:0]                  burst_i;
  logic [REQ_W-1:0]                  req_i;
  logic [FIFO_NUM-1:0]               pop;
  logic [FIFO_NUM-1:0]               empty;
  logic [FIFO_NUM-1:0][BURST-1:0]    burst_o;
  logic [FIFO_NUM-1:0][REQ_W-1:0]    req_o;
  logic                              mode;
  logic                              err_o;

  modport master (
    output valid_i, type_i, thread_i, burst_i, req_i, pop,
    input  ready_o, empty, burst_o, req_o, mode, err_o
  );

  modport slave (
    input  valid_i, type_i, thread_i, burst_i, req_i, pop,
    output ready_o, empty, burst_o, req_o, mode, err_o
  );

endinterface

// File: rtl/cntr_bs_fifo.sv
// Single synchronous FIFO with registered full/empty flags and occupancy count;
// the head entry is always presented on data_o.
module cntr_bs_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 48,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push_i & ~full_q;
  assign pop_ok_s  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so an idle FIFO presents an all-zero head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/cntr_bs_buf.sv
// Per-bank request buffer: routes requests into read/write FIFOs by thread,
// gates scheduler pops, tracks write occupancy and drives the read/write mode.
module cntr_bs_buf
  import cntr_pkg::*;
#(
  parameter int RD_FIFO_NUM = 4,
  parameter int WR_FIFO_NUM = 3,
  parameter int DEPTH       = 8,
  parameter int BURST       = 16,
  parameter int REQ_W       = 32,
  parameter int HI_WM       = 16,
  parameter int LO_WM       = 4
) (
  input  logic         clk,
  input  logic         rst,
  cntr_bs_buf_if.slave bus
);

  localparam int FIFO_NUM = fifo_num(RD_FIFO_NUM, WR_FIFO_NUM);
  localparam int IDX_W    = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int WCNT_W   = $clog2(WR_FIFO_NUM * DEPTH + 1);
  localparam int ENTRY_W  = BURST + REQ_W;

  logic                              in_range_s;
  logic [IDX_W-1:0]                  tgt_s;
  logic                              ready_s;
  logic                              push_s;
  logic                              wr_push_s;
  logic [FIFO_NUM-1:0]               push_vec_s;
  logic [FIFO_NUM-1:0]               pop_ok_s;
  logic [FIFO_NUM-1:0]               full_s;
  logic [FIFO_NUM-1:0]               empty_s;
  logic [FIFO_NUM-1:0]               empty_nx_s;
  logic [FIFO_NUM-1:0][CNT_W-1:0]    count_s;
  logic [FIFO_NUM-1:0][ENTRY_W-1:0]  head_s;
  logic [FIFO_NUM-1:0][BURST-1:0]    burst_s;
  logic [FIFO_NUM-1:0][REQ_W-1:0]    req_s;
  logic                              rd_any_nx_s;
  logic                              wr_any_nx_s;
  logic [WCNT_W-1:0]                 wr_cnt_q;
  logic [WCNT_W-1:0]                 wr_cnt_d;
  logic                              err_d;
  logic                              err_q;
  mode_e                             mode_q;

  always_comb begin
    in_range_s = 1'b0;
    tgt_s      = '0;
    if (bus.type_i == READ) begin
      in_range_s = (int'(bus.thread_i) < RD_FIFO_NUM);
      tgt_s      = IDX_W'(fifo_idx(1'b1, int'(bus.thread_i), RD_FIFO_NUM));
    end else begin
      in_range_s = (int'(bus.thread_i) < WR_FIFO_NUM);
      tgt_s      = IDX_W'(fifo_idx(1'b0, int'(bus.thread_i), RD_FIFO_NUM));
    end
  end

  // An out-of-range thread can map past the last FIFO, so never index with it.
  assign ready_s   = in_range_s ? ~full_s[tgt_s] : 1'b0;
  assign push_s    = bus.valid_i & ready_s;
  assign wr_push_s = push_s & (bus.type_i == WRITE);
  assign pop_ok_s  = bus.pop & ~empty_s;

  always_comb begin
    push_vec_s = '0;
    empty_nx_s = empty_s;
    for (int i = 0; i < FIFO_NUM; i++) begin
      push_vec_s[i] = push_s & (tgt_s == IDX_W'(i));
      if (push_vec_s[i]) begin
        empty_nx_s[i] = 1'b0;
      end else if (pop_ok_s[i]) begin
        empty_nx_s[i] = (count_s[i] == CNT_W'(1));
      end else begin
        empty_nx_s[i] = empty_s[i];
      end
    end
  end

  assign rd_any_nx_s = |(~empty_nx_s[RD_FIFO_NUM-1:0]);
  assign wr_any_nx_s = |(~empty_nx_s[FIFO_NUM-1:RD_FIFO_NUM]);

  assign wr_cnt_d = wr_cnt_q + WCNT_W'(wr_push_s)
                  - WCNT_W'(popcnt(32'(pop_ok_s[FIFO_NUM-1:RD_FIFO_NUM])));

  assign err_d = (bus.valid_i & ~in_range_s) | (|(bus.pop & empty_s));

  for (genvar g = 0; g < FIFO_NUM; g++) begin : g_fifo
    cntr_bs_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_vec_s[g]),
      .pop_i   (pop_ok_s[g]),
      .data_i  ({bus.burst_i, bus.req_i}),
      .data_o  (head_s[g]),
      .full_o  (full_s[g]),
      .empty_o (empty_s[g]),
      .count_o (count_s[g])
    );
    assign burst_s[g] = head_s[g][ENTRY_W-1:REQ_W];
    assign req_s[g]   = head_s[g][REQ_W-1:0];
  end

  // Write occupancy and the one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  // Mode follows the next-cycle occupancy so it changes on the same edge as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_RD;
    end else begin
      case (mode_q)
        MODE_RD: begin
          if ((int'(wr_cnt_d) >= HI_WM) || (!rd_any_nx_s && wr_any_nx_s)) begin
            mode_q <= MODE_WR;
          end else begin
            mode_q <= MODE_RD;
          end
        end
        MODE_WR: begin
          if (((int'(wr_cnt_d) <= LO_WM) && rd_any_nx_s) || !wr_any_nx_s) begin
            mode_q <= MODE_RD;
          end else begin
            mode_q <= MODE_WR;
          end
        end
        default: mode_q <= MODE_RD;
      endcase
    end
  end

  assign bus.ready_o = ready_s;
  assign bus.empty   = empty_s;
  assign bus.burst_o = burst_s;
  assign bus.req_o   = req_s;
  assign bus.mode    = logic'(mode_q);
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_cntr_bs_buf.sv
// Randomized plus directed bench for cntr_bs_buf against a queue-based model.
module tb_cntr_bs_buf;

  localparam int RD    = 4;
  localparam int WR    = 3;
  localparam int FN    = RD + WR;
  localparam int DEPTH = 8;
  localparam int HI    = 16;
  localparam int LO    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cntr_bs_buf_if #(.RD_FIFO_NUM(RD), .WR_FIFO_NUM(WR), .BURST(16), .REQ_W(32)) bus ();

  cntr_bs_buf #(
    .RD_FIFO_NUM(RD), .WR_FIFO_NUM(WR), .DEPTH(DEPTH), .BURST(16), .REQ_W(32),
    .HI_WM(HI), .LO_WM(LO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mb [FN][$];
  logic [31:0] mr [FN][$];
  logic        m_mode;
  logic        m_err;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < FN; i++) begin
      mb[i].delete();
      mr[i].delete();
    end
    m_mode = 1'b1;
    m_err  = 1'b0;
  endtask

  function automatic int m_wr_cnt();
    int s = 0;
    for (int i = RD; i < FN; i++) s += mb[i].size();
    return s;
  endfunction

  function automatic bit m_in_range(input logic t, input int th);
    return t ? (th < RD) : (th < WR);
  endfunction

  function automatic int m_idx(input logic t, input int th);
    return t ? th : RD + th;
  endfunction

  task automatic check_state();
    for (int i = 0; i < FN; i++) begin
      chk($sformatf("empty%0d", i), 64'(bus.empty[i]), 64'(mb[i].size() == 0));
      if (mb[i].size() != 0) begin
        chk($sformatf("burst%0d", i), 64'(bus.burst_o[i]), 64'(mb[i][0]));
        chk($sformatf("req%0d", i), 64'(bus.req_o[i]), 64'(mr[i][0]));
      end
    end
    chk("mode", 64'(bus.mode), 64'(m_mode));
    chk("err", 64'(bus.err_o), 64'(m_err));
    chk("wr_cnt", 64'(dut.wr_cnt_q), 64'(m_wr_cnt()));
  endtask

  // One clock of stimulus: drive, check ready, advance model, check state.
  task automatic step(input logic v, input logic t, input logic [1:0] th,
                      input logic [15:0] b, input logic [31:0] r, input logic [FN-1:0] p);
    bit exp_rdy;
    bit pre_empty [FN];
    bit rd_any;
    int w;
    bus.valid_i  = v;
    bus.type_i   = t;
    bus.thread_i = th;
    bus.burst_i  = b;
    bus.req_i    = r;
    bus.pop      = p;
    #1;
    exp_rdy = m_in_range(t, int'(th)) && (mb[m_idx(t, int'(th))].size() < DEPTH);
    chk("ready", 64'(bus.ready_o), 64'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < FN; i++) pre_empty[i] = (mb[i].size() == 0);
    m_err = v && !m_in_range(t, int'(th));
    if (v && exp_rdy) begin
      mb[m_idx(t, int'(th))].push_back(b);
      mr[m_idx(t, int'(th))].push_back(r);
    end
    for (int i = 0; i < FN; i++) begin
      if (p[i]) begin
        if (pre_empty[i]) m_err = 1'b1;
        else begin
          void'(mb[i].pop_front());
          void'(mr[i].pop_front());
        end
      end
    end
    w = m_wr_cnt();
    rd_any = 1'b0;
    for (int i = 0; i < RD; i++) if (mb[i].size() != 0) rd_any = 1'b1;
    if (m_mode) begin
      if (w >= HI || (!rd_any && w > 0)) m_mode = 1'b0;
    end else begin
      if ((w <= LO && rd_any) || w == 0) m_mode = 1'b1;
    end
    #1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, '0);
  endtask

  task automatic drain();
    logic [FN-1:0] p;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      p = '0;
      for (int i = 0; i < FN; i++) p[i] = (mb[i].size() != 0);
      if (p != '0) step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, p);
    end
  endtask

  initial begin
    logic [FN-1:0] p;
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.type_i = 1'b1; bus.thread_i = '0;
    bus.burst_i = '0; bus.req_i = '0; bus.pop = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    for (int i = 0; i < FN; i++) begin
      chk("rst_burst", 64'(bus.burst_o[i]), 64'd0);
      chk("rst_req", 64'(bus.req_o[i]), 64'd0);
    end
    rst = 1'b0;

    // Single read push, then pop it.
    step(1'b1, 1'b1, 2'd2, 16'h00A5, 32'h1234_0001, '0);
    step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, 7'b0000100);

    // Fill read FIFO 0, refused push with concurrent pop, neighbour accepted.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, 2'd0, 16'(k + 1), 32'(100 + k), '0);
    step(1'b1, 1'b1, 2'd0, 16'hBEEF, 32'hDEAD, 7'b0000001);
    step(1'b1, 1'b1, 2'd1, 16'h0111, 32'h0222, '0);

    // Watermarks with reads pending.
    for (int k = 0; k < HI; k++) step(1'b1, 1'b0, 2'(k % 3), 16'(16'h4000 + k), 32'(k), '0);
    for (int k = 0; k < HI - LO; k++) step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, 7'(1 << (RD + k % 3)));
    drain();

    // Lone write with reads empty, then pop it.
    step(1'b1, 1'b0, 2'd1, 16'h5555, 32'h6666, '0);
    step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, 7'b0100000);

    // Error sources.
    step(1'b0, 1'b1, 2'd0, 16'h0, 32'h0, 7'b0100000);
    idle();
    step(1'b1, 1'b0, 2'd3, 16'h7777, 32'h8888, '0);
    idle();

    // Randomized fill/drain phases.
    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < FN; i++)
          p[i] = ($urandom_range(0, 99) < ((ph % 2 == 1) ? 45 : 8));
        step(1'b1 & ($urandom_range(0, 99) < ((ph % 2 == 1) ? 30 : 85)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'($urandom), 32'($urandom), p);
      end
    end

    // Asynchronous reset with entries buffered.
    drain();
    for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom_range(0, 1)), 2'(k % 3), 16'(k), 32'(k), '0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_state();
    chk("async_empty", 64'(bus.empty), 64'({FN{1'b1}}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 2'd3, 16'hA5A5, 32'h5A5A, '0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
